freq_disp_scan: RTL and testbench

FREQ_DISP_SCAN -- requirements
Module: freq_disp_scan

---
 rtl/freq_disp_scan.sv | 204 ++++++++++++++++++++
 tb/tb_freq_disp_scan.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/freq_disp_scan.sv
// -----------------------------------------------------------------------------
// freq_disp_scan
//   Multiplexed 8-digit, 7-segment scanner for a frequency meter display.
//   Digits 0-3 show the measured ("real") value and digits 4-7 show the
//   theoretical value, each as four BCD digits from thousands down to ones.
//   Each digit is preceded by an all-off blank period that suppresses ghosting.
//   A whole frame is decoded from one 32-bit snapshot, so the displayed value
//   never tears when the input changes mid-frame.
//
// Parameters
//   DWELL       clk cycles each digit is lit (>= 1)
//   BLANK_CYC   all-off clk cycles before each digit (>= 1)
//
// Ports
//   clk          display clock, rising edge
//   rst_n        asynchronous active-low reset
//   freq_data    8 BCD nibbles, [31:16] real thou..one, [15:0] theo thou..one
//   hold         high at the frame boundary keeps the previous snapshot
//   seg_sel      active-low one-hot digit enable (bit i low lights digit i)
//   seg_code     active-low segments {dp,g,f,e,d,c,b,a}
//   frame_start  one-cycle pulse following every snapshot load
// -----------------------------------------------------------------------------
module freq_disp_scan #(
  parameter int DWELL     = 10,
  parameter int BLANK_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] freq_data,
  input  logic        hold,
  output logic [7:0]  seg_sel,
  output logic [7:0]  seg_code,
  output logic        frame_start
);

  // Counter only has to reach max(DWELL, BLANK_CYC) - 1.
  localparam int MAXC = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t          r_state;
  logic [2:0]      r_idx;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_snap;
  logic [7:0]      r_sel;
  logic [7:0]      r_code;
  logic            r_frame_start;

  state_t          w_state_nxt;
  logic [2:0]      w_idx_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [7:0]      w_sel_nxt;
  logic [7:0]      w_code_nxt;
  logic            w_load;
  logic [31:0]     w_snap_eff;

  // BCD nibble to active-low segments; A-F show a dash (segment g only).
  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'd0:    code = 8'hC0;
      4'd1:    code = 8'hF9;
      4'd2:    code = 8'hA4;
      4'd3:    code = 8'hB0;
      4'd4:    code = 8'h99;
      4'd5:    code = 8'h92;
      4'd6:    code = 8'h82;
      4'd7:    code = 8'hF8;
      4'd8:    code = 8'h80;
      4'd9:    code = 8'h90;
      default: code = 8'hBF;
    endcase
    return code;
  endfunction

  // Final segment code for digit idx of a snapshot, including leading-zero
  // blanking within its group of four and the decimal point on digit 3.
  // Any non-zero nibble (dashes included) stops blanking.
  function automatic logic [7:0] digit_code(input logic [31:0] snap,
                                            input logic [2:0]  idx);
    logic [15:0] grp;
    logic [3:0]  nib;
    logic        blank;
    logic [7:0]  code;
    grp = idx[2] ? snap[15:0] : snap[31:16];
    case (idx[1:0])
      2'd0: begin
        nib   = grp[15:12];
        blank = (grp[15:12] == 4'd0);
      end
      2'd1: begin
        nib   = grp[11:8];
        blank = (grp[15:8] == 8'd0);
      end
      2'd2: begin
        nib   = grp[7:4];
        blank = (grp[15:4] == 12'd0);
      end
      default: begin
        nib   = grp[3:0];
        blank = 1'b0;
      end
    endcase
    if (blank) begin
      code = 8'hFF;
    end else begin
      code = seg_decode(nib);
    end
    if (idx == 3'd3) begin
      code[7] = 1'b0;
    end else begin
      code[7] = 1'b1;
    end
    return code;
  endfunction

  // Snapshot load condition: very first blank cycle of digit 0, hold low.
  // With BLANK_CYC == 1 this is also the edge that lights digit 0, so the
  // decoder looks through the load mux at the value being captured.
  always_comb begin
    w_load     = (r_state == ST_BLANK) && (r_idx == 3'd0) &&
                 (r_cnt == '0) && !hold;
    w_snap_eff = w_load ? freq_data : r_snap;
  end

  // Next-state and registered-output values for the BLANK/SHOW scan FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_sel_nxt   = r_sel;
    w_code_nxt  = r_code;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = '0;
          w_sel_nxt   = ~(8'h01 << r_idx);
          w_code_nxt  = digit_code(w_snap_eff, r_idx);
        end else begin
          w_state_nxt = ST_BLANK;
        end
      end
      ST_SHOW: begin
        if (r_cnt == DWELL_LAST) begin
          w_state_nxt = ST_BLANK;
          w_idx_nxt   = r_idx + 3'd1;
          w_cnt_nxt   = '0;
          w_sel_nxt   = 8'hFF;
          w_code_nxt  = 8'hFF;
        end else begin
          w_state_nxt = ST_SHOW;
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_idx_nxt   = 3'd0;
        w_cnt_nxt   = '0;
        w_sel_nxt   = 8'hFF;
        w_code_nxt  = 8'hFF;
      end
    endcase
  end

  // FSM state, counters and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BLANK;
      r_idx   <= 3'd0;
      r_cnt   <= '0;
      r_sel   <= 8'hFF;
      r_code  <= 8'hFF;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
      r_code  <= w_code_nxt;
    end
  end

  // Snapshot register and the frame_start pulse that follows each load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap        <= 32'h0000_0000;
      r_frame_start <= 1'b0;
    end else begin
      r_snap        <= w_snap_eff;
      r_frame_start <= w_load;
    end
  end

  assign seg_sel     = r_sel;
  assign seg_code    = r_code;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_freq_disp_scan.sv
// -----------------------------------------------------------------------------
// tb_freq_disp_scan
//   Directed, table-driven bench for freq_disp_scan at default parameters
//   (frame = 88 cycles: per digit 1 blank + 10 lit). Expected segment codes
//   are hand-computed per digit; timing expectations are derived from the
//   number of clock edges since reset release.
// -----------------------------------------------------------------------------
module tb_freq_disp_scan;

  logic        clk;
  logic        rst_n;
  logic [31:0] freq_data;
  logic        hold;
  logic [7:0]  seg_sel;
  logic [7:0]  seg_code;
  logic        frame_start;

  int n_checks;
  int n_errors;
  int k;          // rising edges since last reset release

  typedef struct {
    logic [31:0] data;
    logic [63:0] codes;   // digit i code at [8i +: 8]
  } vec_t;

  vec_t vecs [6];

  freq_disp_scan #(.DWELL(10), .BLANK_CYC(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .freq_data   (freq_data),
    .hold        (hold),
    .seg_sel     (seg_sel),
    .seg_code    (seg_code),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pack8(input logic [7:0] c0, input logic [7:0] c1,
                                        input logic [7:0] c2, input logic [7:0] c3,
                                        input logic [7:0] c4, input logic [7:0] c5,
                                        input logic [7:0] c6, input logic [7:0] c7);
    return {c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  // Compare outputs after edge k against the expected scan position.
  task automatic check_cycle(input logic [63:0] codes, input bit load);
    int m;
    int d;
    logic [7:0] e_sel;
    logic [7:0] e_code;
    logic [7:0] e_fs;
    m = (k - 1) % 88;
    d = m / 11;
    if ((m % 11) < 10) begin
      e_sel  = ~(8'h01 << d);
      e_code = codes[d*8 +: 8];
    end else begin
      e_sel  = 8'hFF;
      e_code = 8'hFF;
    end
    e_fs = (m == 0 && load) ? 8'h01 : 8'h00;
    chk("seg_sel", seg_sel, e_sel);
    chk("seg_code", seg_code, e_code);
    chk("frame_start", {7'd0, frame_start}, e_fs);
  endtask

  // One full frame; optionally change freq_data or pulse hold mid-frame.
  task automatic run_frame(input logic [63:0] codes, input bit load,
                           input int chg_at, input logic [31:0] chg_val,
                           input int htog_at);
    for (int c = 0; c < 88; c++) begin
      if (c == chg_at) freq_data = chg_val;
      if (c == htog_at || c == htog_at + 20) hold = ~hold;
      step();
      check_cycle(codes, load);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    k         = 0;
    rst_n     = 1'b0;
    hold      = 1'b0;
    freq_data = 32'h0000_0000;

    vecs[0].data  = 32'h0000_0000;
    vecs[0].codes = pack8(8'hFF, 8'hFF, 8'hFF, 8'h40, 8'hFF, 8'hFF, 8'hFF, 8'hC0);
    vecs[1].data  = 32'h1234_0567;
    vecs[1].codes = pack8(8'hF9, 8'hA4, 8'hB0, 8'h19, 8'hFF, 8'h92, 8'h82, 8'hF8);
    vecs[2].data  = 32'hA000_000F;
    vecs[2].codes = pack8(8'hBF, 8'hC0, 8'hC0, 8'h40, 8'hFF, 8'hFF, 8'hFF, 8'hBF);
    vecs[3].data  = 32'h9876_5432;
    vecs[3].codes = pack8(8'h90, 8'h80, 8'hF8, 8'h02, 8'h92, 8'h99, 8'hB0, 8'hA4);
    vecs[4].data  = 32'h0050_0100;
    vecs[4].codes = pack8(8'hFF, 8'hFF, 8'h92, 8'h40, 8'hFF, 8'hF9, 8'hC0, 8'hC0);
    vecs[5].data  = 32'h0B0C_00E0;
    vecs[5].codes = pack8(8'hFF, 8'hBF, 8'hC0, 8'h3F, 8'hFF, 8'hFF, 8'hBF, 8'hC0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_seg_sel", seg_sel, 8'hFF);
    chk("rst_seg_code", seg_code, 8'hFF);
    chk("rst_frame_start", {7'd0, frame_start}, 8'h00);
    rst_n = 1'b1;
    k = 0;
    #1;
    chk("rel_seg_sel", seg_sel, 8'hFF);

    // Table: each vector applied just before a load edge, checked for a frame
    for (int v = 0; v < 6; v++) begin
      freq_data = vecs[v].data;
      run_frame(vecs[v].codes, 1'b1, -1, 32'h0, -100);
    end

    // No tearing: change during digit 5, old codes for rest of frame
    freq_data = vecs[1].data;
    run_frame(vecs[1].codes, 1'b1, 60, vecs[3].data, -100);
    run_frame(vecs[3].codes, 1'b1, -1, 32'h0, -100);

    // Hold at the boundary: snapshot kept, no frame_start; mid-frame hold
    // toggling has no effect
    hold      = 1'b1;
    freq_data = vecs[2].data;
    run_frame(vecs[3].codes, 1'b0, -1, 32'h0, -100);
    run_frame(vecs[3].codes, 1'b0, -1, 32'h0, 30);
    hold = 1'b0;
    run_frame(vecs[2].codes, 1'b1, 40, vecs[5].data, 10);
    run_frame(vecs[5].codes, 1'b1, -1, 32'h0, -100);

    // Reset during SHOW of digit 4
    freq_data = vecs[4].data;
    for (int c = 0; c < 48; c++) begin
      step();
      check_cycle(vecs[4].codes, 1'b1);
    end
    chk("pre_rst_sel_d4", seg_sel, 8'hEF);
    rst_n = 1'b0;
    #1;
    chk("async_rst_sel", seg_sel, 8'hFF);
    chk("async_rst_code", seg_code, 8'hFF);
    chk("async_rst_fs", {7'd0, frame_start}, 8'h00);
    step();
    chk("held_rst_sel", seg_sel, 8'hFF);
    freq_data = vecs[1].data;
    rst_n = 1'b1;
    k = 0;
    run_frame(vecs[1].codes, 1'b1, -1, 32'h0, -100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
